// File: rtl/cvxif_coproc_responder.sv
// Coprocessor-side CVXIF responder.
// Accepts offloaded custom-3 instructions, computes each result at accept time,
// parks it in an in-order queue with a latency countdown, and returns results
// strictly in issue order on a writeback port that cannot be stalled.

module cvxif_coproc_responder #(
    parameter int unsigned XLEN          = 64,
    parameter int unsigned TRANS_ID_BITS = 3,
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned LONG_LAT      = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     x_issue_valid_i,
    output logic                     x_issue_ready_o,
    input  logic [31:0]              x_off_instr_i,
    input  logic [TRANS_ID_BITS-1:0] x_trans_id_i,
    input  logic [XLEN-1:0]          x_rs1_i,
    input  logic [XLEN-1:0]          x_rs2_i,
    output logic                     x_result_valid_o,
    output logic [TRANS_ID_BITS-1:0] x_result_trans_id_o,
    output logic [XLEN-1:0]          x_result_data_o,
    output logic                     x_result_we_o,
    output logic                     x_result_ex_valid_o,
    output logic [XLEN-1:0]          x_result_ex_cause_o,
    output logic [XLEN-1:0]          x_result_ex_tval_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = (LONG_LAT > 1) ? $clog2(LONG_LAT) : 1;
    localparam int unsigned SH_W  = $clog2(XLEN);

    localparam logic [6:0] OPC_CUSTOM3 = 7'b1111011;
    localparam logic [2:0] F3_ADD      = 3'b000;
    localparam logic [2:0] F3_XOR      = 3'b001;
    localparam logic [2:0] F3_ROL      = 3'b010;
    localparam logic [2:0] F3_NOPW     = 3'b011;
    localparam logic [2:0] F3_DLY      = 3'b100;

    // Queue storage, one slot per in-flight instruction
    logic                     valid_r [DEPTH];
    logic [TRANS_ID_BITS-1:0] tid_r   [DEPTH];
    logic [XLEN-1:0]          data_r  [DEPTH];
    logic                     we_r    [DEPTH];
    logic                     ex_r    [DEPTH];
    logic [XLEN-1:0]          tval_r  [DEPTH];
    logic [CNT_W-1:0]         cnt_r   [DEPTH];

    logic [PTR_W-1:0]         wr_ptr_r;
    logic [PTR_W-1:0]         rd_ptr_r;
    logic [PTR_W:0]           count_r;

    logic                     full_s;
    logic                     push_s;
    logic                     retire_s;

    // Decoded result of the instruction currently offered
    logic [XLEN-1:0]          dec_data_s;
    logic                     dec_we_s;
    logic                     dec_ex_s;
    logic [XLEN-1:0]          dec_tval_s;
    logic [CNT_W-1:0]         dec_cnt_s;
    logic [2*XLEN-1:0]        rot_s;
    logic                     rd_nz_s;

    // Ready ignores a same-cycle pop: a full queue never accepts
    assign full_s          = (count_r == (PTR_W+1)'(DEPTH));
    assign x_issue_ready_o = !full_s && !flush_i;
    assign push_s          = x_issue_valid_i && x_issue_ready_o;
    assign retire_s        = !flush_i && valid_r[rd_ptr_r] && (cnt_r[rd_ptr_r] == CNT_W'(0));

    // Decode and execute the offered instruction; anything unknown becomes an illegal-instruction exception
    always_comb begin
        dec_data_s = '0;
        dec_we_s   = 1'b0;
        dec_ex_s   = 1'b0;
        dec_tval_s = '0;
        dec_cnt_s  = '0;
        rd_nz_s    = (x_off_instr_i[11:7] != 5'd0);
        // Rotating the doubled word keeps the shift-by-zero case correct
        rot_s      = {x_rs1_i, x_rs1_i} << x_rs2_i[SH_W-1:0];
        if ((x_off_instr_i[6:0] == OPC_CUSTOM3) && (x_off_instr_i[31:25] == 7'd0)) begin
            case (x_off_instr_i[14:12])
                F3_ADD: begin
                    dec_data_s = x_rs1_i + x_rs2_i;
                    dec_we_s   = rd_nz_s;
                end
                F3_XOR: begin
                    dec_data_s = x_rs1_i ^ x_rs2_i;
                    dec_we_s   = rd_nz_s;
                end
                F3_ROL: begin
                    dec_data_s = rot_s[2*XLEN-1:XLEN];
                    dec_we_s   = rd_nz_s;
                end
                F3_NOPW: begin
                    dec_data_s = '0;
                    dec_we_s   = 1'b0;
                end
                F3_DLY: begin
                    dec_data_s = x_rs1_i + x_rs2_i;
                    dec_we_s   = rd_nz_s;
                    dec_cnt_s  = CNT_W'(LONG_LAT - 1);
                end
                default: begin
                    dec_ex_s   = 1'b1;
                    dec_tval_s = XLEN'(x_off_instr_i);
                end
            endcase
        end else begin
            dec_ex_s   = 1'b1;
            dec_tval_s = XLEN'(x_off_instr_i);
        end
    end

    // Queue pointers and occupancy; flush empties the queue
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (retire_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, retire_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry contents: load on push, count down every entry in flight, drop the head on retire
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                valid_r[i] <= 1'b0;
                tid_r[i]   <= '0;
                data_r[i]  <= '0;
                we_r[i]    <= 1'b0;
                ex_r[i]    <= 1'b0;
                tval_r[i]  <= '0;
                cnt_r[i]   <= '0;
            end
        end else if (flush_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                valid_r[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (valid_r[i] && (cnt_r[i] != CNT_W'(0))) begin
                    cnt_r[i] <= cnt_r[i] - CNT_W'(1);
                end
                if (retire_s && (PTR_W'(i) == rd_ptr_r)) begin
                    valid_r[i] <= 1'b0;
                end
                // A full queue never pushes, so push and retire never share a slot
                if (push_s && (PTR_W'(i) == wr_ptr_r)) begin
                    valid_r[i] <= 1'b1;
                    tid_r[i]   <= x_trans_id_i;
                    data_r[i]  <= dec_data_s;
                    we_r[i]    <= dec_we_s;
                    ex_r[i]    <= dec_ex_s;
                    tval_r[i]  <= dec_tval_s;
                    cnt_r[i]   <= dec_cnt_s;
                end
            end
        end
    end

    // Writeback presents the head when its countdown has expired; all fields are zero otherwise
    always_comb begin
        x_result_valid_o    = 1'b0;
        x_result_trans_id_o = '0;
        x_result_data_o     = '0;
        x_result_we_o       = 1'b0;
        x_result_ex_valid_o = 1'b0;
        x_result_ex_cause_o = '0;
        x_result_ex_tval_o  = '0;
        if (retire_s) begin
            x_result_valid_o    = 1'b1;
            x_result_trans_id_o = tid_r[rd_ptr_r];
            x_result_data_o     = data_r[rd_ptr_r];
            x_result_we_o       = we_r[rd_ptr_r];
            x_result_ex_valid_o = ex_r[rd_ptr_r];
            x_result_ex_cause_o = ex_r[rd_ptr_r] ? XLEN'(2) : XLEN'(0);
            x_result_ex_tval_o  = tval_r[rd_ptr_r];
        end else begin
            x_result_valid_o    = 1'b0;
        end
    end

endmodule

// File: doc/cvxif_coproc_responder.md
Name: cvxif_coproc_responder

Overview:
Coprocessor-side responder for the CVXIF offload interface. It accepts instructions that the issue stage offloads with a valid/ready handshake, executes a small custom-3 instruction set, and returns results in issue order. Results go out on a writeback port that has no backpressure, tagged with the scoreboard transaction ID. It holds up to DEPTH in-flight instructions and supports a flush.

Parameters:
XLEN, 64, operand/result width
TRANS_ID_BITS, 3, scoreboard transaction ID width
DEPTH, 4, in-flight entries (power of two, >=2)
LONG_LAT, 4, latency in cycles of the DLY op (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active low
flush_i  in  1  discard all in-flight and offered instructions
x_issue_valid_i  in  1  offload request valid
x_issue_ready_o  out  1  responder can accept
x_off_instr_i  in  32  offloaded instruction word
x_trans_id_i  in  TRANS_ID_BITS  scoreboard ID of request
x_rs1_i  in  XLEN  operand a
x_rs2_i  in  XLEN  operand b
x_result_valid_o  out  1  writeback valid (one cycle per result)
x_result_trans_id_o  out  TRANS_ID_BITS  ID of returned result
x_result_data_o  out  XLEN  result data
x_result_we_o  out  1  result writes rd
x_result_ex_valid_o  out  1  result carries exception
x_result_ex_cause_o  out  XLEN  exception cause
x_result_ex_tval_o  out  XLEN  exception tval (zero-extended instruction)

Behaviour:
- Accept: a request is accepted in cycle T when x_issue_valid_i && x_issue_ready_o.
- Ready: x_issue_ready_o = !full && !flush_i. Ready does not depend on a same-cycle pop, so full blocks acceptance even while the head retires.
- Decode: opcode 7'b1111011 with funct7==0. Result is computed at accept and stored in the entry.
  - funct3 000 ADD: rs1+rs2, mod 2^XLEN, latency 1.
  - funct3 001 XOR: latency 1.
  - funct3 010 ROL: rotate rs1 left by rs2[log2(XLEN)-1:0], latency 1.
  - funct3 011 NOPW: data 0, we=0, latency 1.
  - funct3 100 DLY: rs1+rs2, latency LONG_LAT.
  - we=1 for ADD, XOR, ROL and DLY when rd != 0, else we=0.
- Illegal: any other encoding is still accepted. It returns latency 1, ex_valid=1, cause=2, tval=zero-extended instruction, we=0, data=0.
- Entry storage: trans_id, data, we, ex, tval, and a countdown cnt loaded with latency-1.
- Countdown: every cycle, each valid entry with cnt!=0 decrements. Non-head entries keep counting, so a latency-1 op behind a DLY returns the cycle after the DLY returns.
- Retire: when the head is valid and cnt==0, the x_result_* outputs present the head and x_result_valid_o=1. The head pops at that clock edge. Latency-1 ops accepted in cycle T appear in cycle T+1.
- Ordering: strict issue order, at most one result per cycle.
- Quiet outputs: when x_result_valid_o=0, all x_result_* outputs are 0.
- Occupancy: pointers wrap modulo DEPTH. A count of 0..DEPTH gives full/empty. Simultaneous push and pop leaves the count unchanged.
- Flush: in a cycle with flush_i=1, no accept and x_result_valid_o=0. At the edge, all entries are invalidated and pointers and count are zeroed. Results of flushed instructions are never emitted.
- Reset (async, at any time including mid-operation): FIFO empty, pointers 0, x_issue_ready_o=1 after release, all x_result_* = 0.

Test Plan:
- ADD, rs1=5, rs2=7, id=3, accepted in cycle T -> cycle T+1: valid=1, id=3, data=12, we=1, ex_valid=0; cycle T+2: valid=0.
- DLY (LONG_LAT=4, id=1) at T, then ADD id=2 at T+1 -> id=1 valid at T+4, id=2 valid at T+5, never reordered.
- Four DLYs back to back with DEPTH=4 -> ready=0 from T+4 until the first pop; a fifth request held valid is accepted in the cycle after the first result.
- Instruction 0x0000007B with funct3=101 -> next cycle: ex_valid=1, cause=2, tval=0x7B with funct3 bits, we=0.
- Three DLYs in flight, flush_i pulsed for one cycle -> no result for those IDs; a following ADD id=5 returns alone, 1 cycle after accept.
- rst_ni asserted with 2 entries in flight -> outputs immediately 0; after release ready=1, and no stale results appear over 10 cycles.
